// File: rtl/hd63701_xbus_pkg.sv
// Shared definitions for the HD63701 external-bus arbiter.
package hd63701_xbus_pkg;

  typedef enum logic [1:0] {
    StMcu   = 2'd0,
    StHostA = 2'd1,
    StHostD = 2'd2
  } xbus_state_e;

  // Upper address nibble of the internal-ROM shadow region.
  localparam logic [3:0] WP_REGION = 4'hF;

  localparam int unsigned DEFAULT_MCU_SLOTS = 4;

endpackage

// File: rtl/hd63701_sat_cnt.sv
// Saturating counter: synchronous clear (priority), increment on enable, async reset to MAX.
module hd63701_sat_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [W-1:0] MaxV = MAX[W-1:0];

  logic [W-1:0] cnt_q;

  // Count up to MAX and hold there; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= MaxV;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != MaxV)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sat = (cnt_q == MaxV);

endmodule

// File: rtl/hd63701_xbus_arb.sv
// Arbiter sharing the HD63701 external memory between the MCU core and a host.
// The core is held off through a registered clock enable; host grants are
// separated by at least MCU_SLOTS MCU-owned cycles.
// Optional macro HD63701_XBUS_WP_EN: block host writes to the 0xF... region
// and flag them with host_err.
module hd63701_xbus_arb
  import hd63701_xbus_pkg::*;
#(
  parameter int unsigned MCU_SLOTS = DEFAULT_MCU_SLOTS,
  parameter int unsigned AW        = 16
) (
  input  logic          mcu_clx2,
  input  logic          mcu_rst,
  input  logic [AW-1:0] mcu_ad,
  input  logic          mcu_wr,
  input  logic [7:0]    mcu_do,
  output logic [7:0]    mcu_di,
  output logic          mcu_ce,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_ad,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic          host_err,
  output logic [AW-1:0] mem_ad,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  xbus_state_e state_q, state_d;
  logic        ce_q;
  logic        ack_q;
  logic [7:0]  rdata_q;
  logic [7:0]  shadow_q;
  logic        gap_sat;
  logic        grant;
  logic        wp_block;

  assign grant = (state_q == StMcu) && host_req && gap_sat;

  hd63701_sat_cnt #(
    .MAX (MCU_SLOTS)
  ) u_gap (
    .clk (mcu_clx2),
    .rst (mcu_rst),
    .inc (state_q == StMcu),
    .clr (grant),
    .sat (gap_sat)
  );

`ifdef HD63701_XBUS_WP_EN
  logic err_q;

  assign wp_block = host_wr && (host_ad[AW-1:AW-4] == WP_REGION);

  // Error flag rides alongside the ack pulse.
  always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
    if (mcu_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == StHostD) && wp_block;
    end
  end

  assign host_err = err_q;
`else
  assign wp_block = 1'b0;
  assign host_err = 1'b0;
`endif

  // Next state and memory bus steering.
  always_comb begin
    state_d   = state_q;
    mem_ad    = mcu_ad;
    mem_wr    = mcu_wr;
    mem_wdata = mcu_do;
    mcu_di    = mem_rdata;
    unique case (state_q)
      StMcu: begin
        if (grant) state_d = StHostA;
      end
      StHostA: begin
        mem_ad    = host_ad;
        mem_wr    = host_wr && !wp_block;
        mem_wdata = host_wdata;
        mcu_di    = shadow_q;
        state_d   = StHostD;
      end
      StHostD: begin
        mem_ad    = host_ad;
        mem_wr    = 1'b0;
        mem_wdata = host_wdata;
        mcu_di    = shadow_q;
        state_d   = StMcu;
      end
      default: state_d = StMcu;
    endcase
  end

  // State, clock enable, ack pulse, host read data and MCU read-data shadow.
  always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
    if (mcu_rst) begin
      state_q  <= StMcu;
      ce_q     <= 1'b1;
      ack_q    <= 1'b0;
      rdata_q  <= 8'h00;
      shadow_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ack_q   <= 1'b0;
      // Keep the last MCU read visible while the host owns the bus.
      if (state_q == StMcu) shadow_q <= mem_rdata;
      if (grant) ce_q <= 1'b0;
      if (state_q == StHostD) begin
        ack_q <= 1'b1;
        ce_q  <= 1'b1;
        if (!host_wr) rdata_q <= mem_rdata;
      end
    end
  end

  assign mcu_ce     = ce_q;
  assign host_ack   = ack_q;
  assign host_rdata = rdata_q;

endmodule

// File: tb/tb_hd63701_xbus_arb.sv
// Self-checking bench for hd63701_xbus_arb: main instance with MCU_SLOTS=4,
// second instance with MCU_SLOTS=0 for back-to-back spacing.
module tb_hd63701_xbus_arb;

  localparam int unsigned SLOTS = 4;

  logic        clk;
  logic        rst;
  logic [15:0] mcu_ad;
  logic        mcu_wr;
  logic [7:0]  mcu_do;
  logic [7:0]  mcu_di;
  logic        mcu_ce;
  logic        host_req, host_wr;
  logic [15:0] host_ad;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_err;
  logic [15:0] mem_ad;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        h0_req;
  logic [7:0]  mcu_di0;
  logic        mcu_ce0;
  logic        h0_ack;
  logic [7:0]  h0_rdata;
  logic        h0_err;
  logic [15:0] mem_ad0;
  logic        mem_wr0;
  logic [7:0]  mem_wdata0;
  logic [7:0]  mem_rdata0;

  logic [7:0]  mem [0:65535];

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] last_rdata;

  hd63701_xbus_arb #(.MCU_SLOTS(SLOTS), .AW(16)) dut (
    .mcu_clx2   (clk),
    .mcu_rst    (rst),
    .mcu_ad     (mcu_ad),
    .mcu_wr     (mcu_wr),
    .mcu_do     (mcu_do),
    .mcu_di     (mcu_di),
    .mcu_ce     (mcu_ce),
    .host_req   (host_req),
    .host_wr    (host_wr),
    .host_ad    (host_ad),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_err   (host_err),
    .mem_ad     (mem_ad),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  hd63701_xbus_arb #(.MCU_SLOTS(0), .AW(16)) dut0 (
    .mcu_clx2   (clk),
    .mcu_rst    (rst),
    .mcu_ad     (mcu_ad),
    .mcu_wr     (1'b0),
    .mcu_do     (mcu_do),
    .mcu_di     (mcu_di0),
    .mcu_ce     (mcu_ce0),
    .host_req   (h0_req),
    .host_wr    (1'b0),
    .host_ad    (16'h1234),
    .host_wdata (8'h00),
    .host_ack   (h0_ack),
    .host_rdata (h0_rdata),
    .host_err   (h0_err),
    .mem_ad     (mem_ad0),
    .mem_wr     (mem_wr0),
    .mem_wdata  (mem_wdata0),
    .mem_rdata  (mem_rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_ad] <= mem_wdata;
    mem_rdata <= mem[mem_ad];
  end
  assign mem_rdata0 = 8'h00;

  // Scoreboard: every ack pops one expected result.
  always @(negedge clk) begin
    if (host_ack === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: host_ack=1 with nothing outstanding");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (host_rdata !== e.rdata || host_err !== e.err) begin
          n_fail++;
          $display("FAIL sb_ack: rdata=%h err=%b, required rdata=%h err=%b",
                   host_rdata, host_err, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // One host access on the main instance; waits for the grant, checks the
  // two stall cycles, and drops host_req in the ack cycle.
  task automatic host_access(input logic [15:0] a, input logic w, input logic [7:0] d,
                             input logic exp_memwr, input logic exp_err,
                             input string nm, output int n);
    exp_t e;
    e.rdata = w ? last_rdata : mem[a];
    e.err   = exp_err;
    last_rdata = e.rdata;
    exp_q.push_back(e);
    host_ad = a; host_wr = w; host_wdata = d; host_req = 1'b1;
    n = 0;
    while (mcu_ce === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_grant: no grant within 40 cycles, required a grant", nm);
      host_req = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    chk({nm, "_a_memad"}, mem_ad, a);
    chk({nm, "_a_memwr"}, {15'd0, mem_wr}, {15'd0, exp_memwr});
    tick();
    chk({nm, "_d_ce"}, {15'd0, mcu_ce}, 16'd0);
    chk({nm, "_d_memwr"}, {15'd0, mem_wr}, 16'd0);
    tick();
    chk({nm, "_ack_ce"}, {15'd0, mcu_ce}, 16'd1);
    chk({nm, "_ack"}, {15'd0, host_ack}, 16'd1);
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    chk("rst_ce", {15'd0, mcu_ce}, 16'd1);
    chk("rst_ack", {15'd0, host_ack}, 16'd0);
    chk("rst_err", {15'd0, host_err}, 16'd0);
    chk("rst_rdata", {8'd0, host_rdata}, 16'd0);
    rst = 1'b0;
    // Gap starts saturated, so the very first edge grants.
    host_access(16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, "first_read", n);
    chk("first_read_latency", n[15:0], 16'd1);
  endtask

  task automatic test_write_then_mcu_read();
    int n;
    repeat (6) tick();
    host_access(16'h0200, 1'b1, 8'h5A, 1'b1, 1'b0, "wr0200", n);
    chk("wr0200_mem", {8'd0, mem[16'h0200]}, 16'h005A);
    mcu_ad = 16'h0200;
    tick();
    chk("mcu_rd0200", {8'd0, mcu_di}, 16'h005A);
    mcu_ad = 16'h0210; mcu_wr = 1'b1; mcu_do = 8'h3C;
    tick();
    mcu_wr = 1'b0; mcu_ad = 16'h0000;
    chk("mcu_wr0210", {8'd0, mem[16'h0210]}, 16'h003C);
  endtask

  task automatic test_shadow();
    exp_t e;
    mcu_ad = 16'h0300;
    repeat (6) tick();
    e.rdata = mem[16'h1234]; e.err = 1'b0;
    last_rdata = e.rdata;
    exp_q.push_back(e);
    host_ad = 16'h1234; host_wr = 1'b0; host_req = 1'b1;
    tick();
    chk("shadow_a_ce", {15'd0, mcu_ce}, 16'd0);
    chk("shadow_a", {8'd0, mcu_di}, 16'h0077);
    mcu_ad = 16'h0200;
    tick();
    chk("shadow_d", {8'd0, mcu_di}, 16'h0077);
    tick();
    chk("shadow_ack", {15'd0, host_ack}, 16'd1);
    host_req = 1'b0;
    tick();
  endtask

  // Enabled cycles between stalls, counting the ack cycle, are MCU_SLOTS+1.
  task automatic test_back_to_back();
    int n;
    exp_t e;
    e.rdata = mem[16'h1234]; e.err = 1'b0;
    last_rdata = e.rdata;
    repeat (3) exp_q.push_back(e);
    host_ad = 16'h1234; host_wr = 1'b0; host_req = 1'b1;
    for (int a = 0; a < 3; a++) begin
      n = 0;
      while (mcu_ce === 1'b1 && n < 40) begin
        tick();
        n++;
      end
      if (a > 0) chk("b2b_spacing", n[15:0], 16'(SLOTS + 1));
      tick();
      chk("b2b_d_ce", {15'd0, mcu_ce}, 16'd0);
      tick();
      chk("b2b_ack_ce", {15'd0, mcu_ce}, 16'd1);
      chk("b2b_ack", {15'd0, host_ack}, 16'd1);
      if (a == 2) host_req = 1'b0;
    end
    tick();
  endtask

  task automatic test_back_to_back_slots0();
    int n;
    h0_req = 1'b1;
    for (int a = 0; a < 3; a++) begin
      n = 0;
      while (mcu_ce0 === 1'b1 && n < 40) begin
        tick();
        n++;
      end
      if (a > 0) chk("b2b0_spacing", n[15:0], 16'd1);
      tick();
      chk("b2b0_d_ce", {15'd0, mcu_ce0}, 16'd0);
      tick();
      chk("b2b0_ack_ce", {15'd0, mcu_ce0}, 16'd1);
      chk("b2b0_ack", {15'd0, h0_ack}, 16'd1);
      if (a == 2) h0_req = 1'b0;
    end
    tick();
  endtask

  task automatic test_wp();
    int n;
    repeat (6) tick();
`ifdef HD63701_XBUS_WP_EN
    host_access(16'hF010, 1'b1, 8'h99, 1'b0, 1'b1, "wp_wr", n);
    chk("wp_mem", {8'd0, mem[16'hF010]}, 16'h0000);
`else
    host_access(16'hF010, 1'b1, 8'h99, 1'b1, 1'b0, "wp_wr", n);
    chk("wp_mem", {8'd0, mem[16'hF010]}, 16'h0099);
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (6) tick();
    host_ad = 16'h0400; host_wr = 1'b1; host_wdata = 8'h11; host_req = 1'b1;
    tick();
    chk("rmid_a_ce", {15'd0, mcu_ce}, 16'd0);
    #2 rst = 1'b1;
    #1;
    chk("rmid_ce", {15'd0, mcu_ce}, 16'd1);
    chk("rmid_memad", mem_ad, mcu_ad);
    chk("rmid_memwr", {15'd0, mem_wr}, 16'd0);
    chk("rmid_rdata", {8'd0, host_rdata}, 16'd0);
    host_req = 1'b0;
    tick();
    rst = 1'b0;
    last_rdata = 8'h00;
    repeat (3) begin
      tick();
      chk("rmid_no_ack", {15'd0, host_ack}, 16'd0);
    end
    // Gap reloads to MCU_SLOTS, so the first edge after release may grant.
    rst = 1'b1;
    #1 rst = 1'b0;
    host_access(16'h0300, 1'b0, 8'h00, 1'b0, 1'b0, "rmid_read", n);
    chk("rmid_read_latency", n[15:0], 16'd1);
  endtask

  initial begin
    mem[16'h1234] = 8'hA5;
    mem[16'h0300] = 8'h77;
    mcu_ad = 16'h0000; mcu_wr = 1'b0; mcu_do = 8'h00;
    host_req = 1'b0; host_wr = 1'b0; host_ad = 16'h0000; host_wdata = 8'h00;
    h0_req = 1'b0;
    last_rdata = 8'h00;
    test_reset();
    test_write_then_mcu_read();
    test_shadow();
    test_back_to_back();
    test_back_to_back_slots0();
    test_wp();
    test_reset_mid();
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d acks outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
